game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICKS_PER_MOVE, default 50_000_000; clock cycles between head moves (1 s at 50 MHz), legal range 2..2^26-1.
REQ-002 clock  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  level; starts a game from IDLE, LOSE or WIN.
REQ-005 dir_btn  in  4  {up,down,left,right} = bits [3:0]; level, already synchronised.
REQ-006 position  out  4  head cell, index = row*4+col (row = [3:2], col = [1:0]); drives LED matrix.
REQ-007 apple  out  4  apple cell, same encoding; drives LED matrix.
REQ-008 score  out  4  apples eaten in current game.
REQ-009 playing  out  1  high in PLAY.
REQ-010 game_over  out  1  high in LOSE.
REQ-011 won  out  1  high in WIN.

Function
REQ-012 FSM states IDLE, PLAY, LOSE, WIN; transitions: IDLE/LOSE/WIN -start-> PLAY; PLAY -wall-> LOSE; PLAY -score reaches 15-> WIN; start in PLAY is ignored.
REQ-013 On entry to PLAY: position=0, apple=10, score=0, direction=RIGHT, tick counter=0.
REQ-014 Tick counter counts 0..TICKS_PER_MOVE-1 in PLAY only, wraps to 0; move occurs on the edge where the count equals TICKS_PER_MOVE-1; first move lands TICKS_PER_MOVE cycles after PLAY entry.
REQ-015 Direction register updates on every PLAY cycle with any dir_btn bit set; priority up > down > left > right; no buttons means hold; reversal allowed.
REQ-016 A move uses the direction register value before that edge; a button first seen on the move edge applies to the next move.
REQ-017 Move: up row-1, down row+1, left col-1, right col+1; leaving the 4x4 grid (row/col below 0 or above 3) is a wall hit: position holds, no score change, next state LOSE.
REQ-018 If the new position equals apple: score+1 and apple := lfsr; if lfsr equals the new position, apple := lfsr+1 (mod 16); all on the same edge as the move.
REQ-019 Score reaching 15 transitions to WIN on the same edge; position, apple, score freeze in LOSE and WIN.
REQ-020 4-bit LFSR, polynomial x^4+x^3+1, free-runs every cycle in all states; never zero.
REQ-021 Outputs are registered; playing, game_over, won decode directly from state and are mutually exclusive.

Reset
REQ-022 Reset has priority over all inputs, is effective at any state including mid-move, and yields on the next edge: state=IDLE, position=0, apple=10, score=0, direction=RIGHT, tick counter=0, lfsr=4'b0001, playing=game_over=won=0.

Structure
REQ-023 Shared package holds state encodings, direction codes, GRID_DIM=4, START_POS=0, START_APPLE=10, MAX_SCORE=15.
REQ-024 One sub-module, lfsr4 (clock, reset, 4-bit value out); tick counter and FSM stay in game_controller.
REQ-025 position/apple are the sole interface to the LED matrix block; this block holds no LED state.

Verification (TICKS_PER_MOVE=4)
REQ-026 Reset asserted -> position=0, apple=10, score=0, all status flags 0, lfsr=1.
REQ-027 start pulse, no buttons -> position 1, 2, 3 at 4, 8, 12 cycles after PLAY entry; at 16, game_over=1, position stays 3.
REQ-028 start; right for 2 moves, then down for 2 moves -> position 2, 6, 10; on reaching 10: score=1, apple!=10, playing=1.
REQ-029 up and left held together from position 0 -> up chosen; first move is a wall hit: game_over=1, position=0.
REQ-030 reset asserted in PLAY at tick count 2 -> next edge IDLE with REQ-022 values; no move occurs.
REQ-031 From LOSE, start -> PLAY, position=0, apple=10, score=0, game_over=0; force 15 eats -> won=1, score=15, all outputs frozen.

Source files
------------

// File: rtl/game_controller_pkg.sv
// Shared types and constants for the 4x4 snake-style game controller.
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_LOSE,
    ST_WIN
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int         GRID_DIM    = 4;
  localparam logic [3:0] START_POS   = 4'd0;
  localparam logic [3:0] START_APPLE = 4'd10;
  localparam logic [3:0] MAX_SCORE   = 4'd15;
  localparam logic [3:0] LFSR_SEED   = 4'b0001;

  // Result of stepping the head one cell: wall flag plus the candidate cell.
  typedef struct packed {
    logic       wall;
    logic [3:0] pos;
  } move_t;

  // Cell index is row*4+col; stepping past any edge reports a wall hit.
  function automatic move_t next_cell(input logic [3:0] pos, input dir_t dir);
    logic [1:0] row;
    logic [1:0] col;
    move_t      m;
    row    = pos[3:2];
    col    = pos[1:0];
    m.wall = 1'b0;
    m.pos  = pos;
    case (dir)
      DIR_UP:    if (row == 2'd0) m.wall = 1'b1; else m.pos = {row - 2'd1, col};
      DIR_DOWN:  if (row == 2'(GRID_DIM - 1)) m.wall = 1'b1; else m.pos = {row + 2'd1, col};
      DIR_LEFT:  if (col == 2'd0) m.wall = 1'b1; else m.pos = {row, col - 2'd1};
      default:   if (col == 2'(GRID_DIM - 1)) m.wall = 1'b1; else m.pos = {row, col + 2'd1};
    endcase
    return m;
  endfunction

  // Buttons {up,down,left,right}; up wins over down over left over right, none holds.
  function automatic dir_t pick_dir(input logic [3:0] btn, input dir_t cur);
    if (btn[3])      return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else if (btn[1]) return DIR_LEFT;
    else if (btn[0]) return DIR_RIGHT;
    else             return cur;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Player inputs and LED/status outputs of the game controller.
interface game_controller_if;
  logic       start;
  logic [3:0] dir_btn;
  logic [3:0] position;
  logic [3:0] apple;
  logic [3:0] score;
  logic       playing;
  logic       game_over;
  logic       won;

  modport master (
    output start, dir_btn,
    input  position, apple, score, playing, game_over, won
  );

  modport slave (
    input  start, dir_btn,
    output position, apple, score, playing, game_over, won
  );
endinterface

// File: rtl/game_controller_lfsr4.sv
// Free-running 4-bit maximal-length LFSR (x^4+x^3+1); never reaches zero.
module lfsr4
  import game_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] o_value
);

  logic [3:0] r_q;

  // Shift left, feeding back tap bits 3 and 2; seeded with a non-zero value.
  always_ff @(posedge clock) begin
    if (reset) r_q <= LFSR_SEED;
    else       r_q <= {r_q[2:0], r_q[3] ^ r_q[2]};
  end

  assign o_value = r_q;

endmodule

// File: rtl/game_controller.sv
// Game controller: move timer, direction latch, head/apple/score state and FSM.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int TICKS_PER_MOVE = 50_000_000
)(
  input logic              clock,
  input logic              reset,
  game_controller_if.slave gc
);

  localparam int               TICK_W    = 26;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MOVE - 1);

  state_t            r_state;
  dir_t              r_dir;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_pos;
  logic [3:0]        r_apple;
  logic [3:0]        r_score;
  logic              r_playing;
  logic              r_game_over;
  logic              r_won;

  logic [3:0]        w_lfsr;
  logic [3:0]        w_score_inc;
  move_t             w_move;

  lfsr4 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .o_value (w_lfsr)
  );

  // The move always uses the direction held before the move edge.
  assign w_move      = next_cell(r_pos, r_dir);
  assign w_score_inc = r_score + 4'd1;

  // Game FSM with registered board state and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_RIGHT;
      r_tick      <= '0;
      r_pos       <= START_POS;
      r_apple     <= START_APPLE;
      r_score     <= 4'd0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_won       <= 1'b0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          r_dir <= pick_dir(gc.dir_btn, r_dir);
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (w_move.wall) begin
              r_state     <= ST_LOSE;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
            end else begin
              r_pos <= w_move.pos;
              if (w_move.pos == r_apple) begin
                r_score <= w_score_inc;
                // Never place the apple under the head that just ate it.
                r_apple <= (w_lfsr == w_move.pos) ? w_lfsr + 4'd1 : w_lfsr;
                if (w_score_inc == MAX_SCORE) begin
                  r_state   <= ST_WIN;
                  r_playing <= 1'b0;
                  r_won     <= 1'b1;
                end
              end
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        ST_IDLE, ST_LOSE, ST_WIN: begin
          if (gc.start) begin
            r_state     <= ST_PLAY;
            r_dir       <= DIR_RIGHT;
            r_tick      <= '0;
            r_pos       <= START_POS;
            r_apple     <= START_APPLE;
            r_score     <= 4'd0;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
            r_won       <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_playing   <= 1'b0;
          r_game_over <= 1'b0;
          r_won       <= 1'b0;
        end
      endcase
    end
  end

  assign gc.position  = r_pos;
  assign gc.apple     = r_apple;
  assign gc.score     = r_score;
  assign gc.playing   = r_playing;
  assign gc.game_over = r_game_over;
  assign gc.won       = r_won;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a short move period.
module tb_game_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errs;

  game_controller_if gc_if();

  game_controller #(.TICKS_PER_MOVE(4)) dut (
    .clock (clk),
    .reset (rst),
    .gc    (gc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] btn;
    int         n;
    logic [3:0] pos;
    logic [3:0] apple;
    logic       chk_apple;
    logic [3:0] score;
    logic [2:0] flags;   // {playing, game_over, won}
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    n_checks++;
    if (act === bad) begin
      n_errs++;
      $display("FAIL %s actual=%0h must differ from %0h", name, act, bad);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] steer(input logic [3:0] p, input logic [3:0] t);
    if (p[1:0] < t[1:0])      return 4'b0001;
    else if (p[1:0] > t[1:0]) return 4'b0010;
    else if (p[3:2] < t[3:2]) return 4'b0100;
    else                      return 4'b1000;
  endfunction

  initial begin
    logic [3:0] target;
    logic [3:0] snap_apple;
    int         moves;

    n_checks = 0;
    n_errs   = 0;
    rst            = 1'b0;
    gc_if.start    = 1'b0;
    gc_if.dir_btn  = 4'b0000;

    //          rst   start btn      n  pos    apple  chkA  score  flags
    vec[0]  = '{1'b1, 1'b0, 4'b0000, 1, 4'd0,  4'd10, 1'b1, 4'd0, 3'b000};
    vec[1]  = '{1'b0, 1'b1, 4'b0000, 1, 4'd0,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[2]  = '{1'b0, 1'b0, 4'b0000, 4, 4'd1,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[3]  = '{1'b0, 1'b0, 4'b0000, 4, 4'd2,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[4]  = '{1'b0, 1'b0, 4'b0000, 4, 4'd3,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[5]  = '{1'b0, 1'b0, 4'b0000, 4, 4'd3,  4'd10, 1'b1, 4'd0, 3'b010};
    vec[6]  = '{1'b0, 1'b1, 4'b0000, 1, 4'd0,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[7]  = '{1'b0, 1'b1, 4'b0001, 4, 4'd1,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[8]  = '{1'b0, 1'b0, 4'b0001, 4, 4'd2,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[9]  = '{1'b0, 1'b0, 4'b0100, 4, 4'd6,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[10] = '{1'b0, 1'b0, 4'b0100, 4, 4'd10, 4'd0,  1'b0, 4'd1, 3'b100};
    vec[11] = '{1'b1, 1'b0, 4'b0000, 1, 4'd0,  4'd10, 1'b1, 4'd0, 3'b000};
    vec[12] = '{1'b0, 1'b1, 4'b0000, 1, 4'd0,  4'd10, 1'b1, 4'd0, 3'b100};
    vec[13] = '{1'b0, 1'b0, 4'b1010, 4, 4'd0,  4'd10, 1'b1, 4'd0, 3'b010};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst           = vec[i].rst;
      gc_if.start   = vec[i].start;
      gc_if.dir_btn = vec[i].btn;
      cycles(vec[i].n);
      chk($sformatf("v%0d_pos", i), 32'(gc_if.position), 32'(vec[i].pos));
      if (vec[i].chk_apple)
        chk($sformatf("v%0d_apple", i), 32'(gc_if.apple), 32'(vec[i].apple));
      else
        chk_ne($sformatf("v%0d_apple", i), 32'(gc_if.apple), 32'(gc_if.position));
      chk($sformatf("v%0d_score", i), 32'(gc_if.score), 32'(vec[i].score));
      chk($sformatf("v%0d_flags", i),
          32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'(vec[i].flags));
      if (vec[i].rst) begin
        chk($sformatf("v%0d_lfsr", i), 32'(dut.u_lfsr.o_value), 32'd1);
        chk($sformatf("v%0d_tick", i), 32'(dut.r_tick), 32'd0);
      end
      if (i == 10) chk_ne("eat_apple_moved", 32'(gc_if.apple), 32'd10);
    end
    rst = 1'b0;

    // Restart from LOSE and eat fifteen apples.
    gc_if.start   = 1'b1;
    gc_if.dir_btn = 4'b0000;
    cycles(1);
    gc_if.start   = 1'b0;
    chk("restart_pos",   32'(gc_if.position), 32'd0);
    chk("restart_apple", 32'(gc_if.apple), 32'd10);
    chk("restart_score", 32'(gc_if.score), 32'd0);
    chk("restart_flags", 32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'b100);

    moves  = 0;
    target = 4'd0;
    for (int k = 1; k <= 15; k++) begin
      target = gc_if.apple;
      while (gc_if.position != target && moves < 200) begin
        gc_if.dir_btn = steer(gc_if.position, target);
        cycles(4);
        moves++;
      end
      chk($sformatf("eat%0d_score", k), 32'(gc_if.score), 32'(k));
      if (k < 15) chk_ne($sformatf("eat%0d_apple", k), 32'(gc_if.apple), 32'(gc_if.position));
    end
    chk("eat_budget", 32'(moves < 200), 32'd1);
    chk("win_flags", 32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'b001);

    // Frozen in WIN even with buttons held.
    snap_apple    = gc_if.apple;
    gc_if.dir_btn = 4'b1000;
    cycles(12);
    chk("win_pos_frozen",   32'(gc_if.position), 32'(target));
    chk("win_apple_frozen", 32'(gc_if.apple), 32'(snap_apple));
    chk("win_score_frozen", 32'(gc_if.score), 32'd15);
    chk("win_flags_frozen", 32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'b001);

    // Reset mid-move at tick count 2.
    gc_if.dir_btn = 4'b0000;
    gc_if.start   = 1'b1;
    cycles(1);
    gc_if.start   = 1'b0;
    cycles(2);
    chk("mid_tick", 32'(dut.r_tick), 32'd2);
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_pos",   32'(gc_if.position), 32'd0);
    chk("mid_rst_apple", 32'(gc_if.apple), 32'd10);
    chk("mid_rst_score", 32'(gc_if.score), 32'd0);
    chk("mid_rst_flags", 32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'b000);
    chk("mid_rst_tick",  32'(dut.r_tick), 32'd0);
    chk("mid_rst_lfsr",  32'(dut.u_lfsr.o_value), 32'd1);
    rst = 1'b0;
    cycles(8);
    chk("idle_no_move",  32'(gc_if.position), 32'd0);
    chk("idle_flags",    32'({gc_if.playing, gc_if.game_over, gc_if.won}), 32'b000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
